// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests and
// presents the fetched instruction to decode with stall hold and redirect kill.
module pc_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pcs_w,
    input  logic [ADDR_W-1:0]  pc_target_w,
    input  logic               branch_taken_e,
    input  logic [ADDR_W-1:0]  branch_target_e,
    input  logic               stall_f,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_f,
    output logic [ADDR_W-1:0]  pc_f,
    output logic [ADDR_W-1:0]  pc_plus4_f,
    output logic               instr_valid_f
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc_q;
    logic               kill;

    logic               redir;
    logic [ADDR_W-1:0]  target_raw;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_inc;

    // Write-back redirect wins over execute redirect; targets are word aligned.
    assign redir      = pcs_w | branch_taken_e;
    assign target_raw = pcs_w ? pc_target_w : branch_target_e;
    assign target     = target_raw & ~ADDR_W'(3);
    assign pc_inc     = pc_q + ADDR_W'(4);

    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc_q;

    // kill marks an outstanding response whose address became stale after grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pc_q          <= RESET_PC;
            kill          <= 1'b0;
            instr_f       <= '0;
            pc_f          <= RESET_PC;
            pc_plus4_f    <= RESET_PC + ADDR_W'(4);
            instr_valid_f <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redir) pc_q <= target;
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (redir) begin
                        pc_q <= target;
                        if (imem_gnt) begin
                            kill  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redir) begin
                            kill  <= 1'b0;
                            if (redir) pc_q <= target;
                            state <= S_REQ;
                        end else begin
                            instr_f       <= imem_rdata;
                            pc_f          <= pc_q;
                            pc_plus4_f    <= pc_inc;
                            instr_valid_f <= 1'b1;
                            state         <= S_HOLD;
                        end
                    end else if (redir) begin
                        kill <= 1'b1;
                        pc_q <= target;
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        instr_valid_f <= 1'b0;
                        pc_q          <= target;
                        state         <= S_REQ;
                    end else if (!stall_f) begin
                        instr_valid_f <= 1'b0;
                        pc_q          <= pc_inc;
                        state         <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch-stage consumer of the PCS redirect signal produced by the decoder's PC logic; it is the other end of the PC-source interface.
- Owns the PC register and applies write-back redirects (PCS) and execute-stage branch redirects.
- Drives a single-outstanding request/grant/response handshake to instruction memory.
- Presents the fetched instruction and its PC to decode, with stall hold and kill of stale responses.

Parameters:
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pcs_w  in  1  write-back PC-source select (PCS piped to WB); redirect to pc_target_w.
- pc_target_w  in  ADDR_W  WB redirect target.
- branch_taken_e  in  1  execute-stage taken branch; redirect to branch_target_e.
- branch_target_e  in  ADDR_W  EX redirect target.
- stall_f  in  1  decode cannot accept the instruction this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address (equals pc_q).
- imem_gnt  in  1  memory accepted request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  INSTR_W  response instruction.
- instr_f  out  INSTR_W  fetched instruction to decode.
- pc_f  out  ADDR_W  address of instr_f.
- pc_plus4_f  out  ADDR_W  pc_f+4, wraps modulo 2^ADDR_W.
- instr_valid_f  out  1  instr_f/pc_f valid.

Behaviour:
- Reset (async, any state, including mid-transaction):
  - pc_q=RESET_PC, state=IDLE.
  - imem_req=0, instr_valid_f=0, instr_f=0, pc_f=RESET_PC, kill=0.
  - A response arriving after reset deassert for a pre-reset request is dropped only if kill is set. Memory is also reset, so no such response is expected.
- Redirect:
  - redir = pcs_w | branch_taken_e.
  - target = pcs_w ? pc_target_w : branch_target_e, so pcs_w has priority when both are high.
  - target[1:0] is forced to 0.
  - A redirect always overrides stall_f.
- All outputs are registered except imem_req/imem_addr, which are decoded from state and pc_q.
- PC arithmetic: pc_q+4 wraps modulo 2^ADDR_W with no flag (0xFFFFFFFC -> 0x00000000).
- States and transitions:
  - IDLE: imem_req=0. Next cycle -> REQ. If redir, pc_q=target.
  - REQ: imem_req=1, imem_addr=pc_q.
    - redir: pc_q=target, stay REQ. The address may change before grant; the memory samples the address only on gnt.
    - else if imem_gnt: -> WAIT.
    - Simultaneous redir and gnt: the granted address is stale. Set kill=1, pc_q=target, -> WAIT.
  - WAIT: imem_req=0, one transaction outstanding.
    - rvalid with kill=1 or redir this cycle: discard data, kill=0, pc_q=target if redir, -> REQ.
    - rvalid, no kill, no redir: instr_f=rdata, pc_f=pc_q, pc_plus4_f=pc_q+4, instr_valid_f=1, -> HOLD.
    - redir without rvalid: kill=1, pc_q=target, stay WAIT.
  - HOLD: instr_valid_f=1; instr_f, pc_f and pc_plus4_f are held stable.
    - redir: instr_valid_f=0, pc_q=target, -> REQ.
    - else if !stall_f: instruction consumed this cycle; instr_valid_f=0, pc_q=pc_q+4, -> REQ.
    - else (stall_f): hold.
- Throughput: with zero-wait memory (gnt in REQ, rvalid the next cycle), one instruction per 3 cycles. There is never more than one outstanding request.
- instr_valid_f is never 1 for a killed response.

Test Plan:
- Reset, RESET_PC=0x100, release; gnt in first REQ, rvalid the next cycle with rdata=0xE3A01005 -> imem_addr=0x100 in first REQ; instr_f=0xE3A01005, pc_f=0x100, pc_plus4_f=0x104, instr_valid_f=1; next request addr=0x104.
- stall_f=1 for 4 cycles in HOLD -> instr_valid_f=1 and instr_f/pc_f stable for all 4 cycles, no imem_req; after release, next imem_addr=pc_f+4.
- branch_taken_e=1, branch_target_e=0x2002 in WAIT, rvalid 2 cycles later -> response discarded, instr_valid_f stays 0, next imem_addr=0x2000.
- pcs_w=1 (target 0x400) and branch_taken_e=1 (target 0x800) in the same cycle -> next imem_addr=0x400.
- Redirect (0x40) in HOLD while stall_f=1 -> instr_valid_f=0 next cycle, imem_req=1 with addr 0x40.
- pc_f=0xFFFFFFFC consumed -> next imem_addr=0x00000000. Assert rst mid-WAIT -> all outputs at reset values immediately, no clock edge needed.
